// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: pipelined immediate extender with a registered-ready skid buffer
module imm_ext_pipe #(
  parameter int IN_W = 15,
  parameter int OUT_W = 32,
  parameter int SHIFT_AMT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);
  logic [OUT_W-1:0] sx, zx, up, ext, main_d, skid_d;
  logic main_v, skid_v, it, ot;
  always_comb begin
    sx = {OUT_W{in_imm[IN_W-1]}};
    sx[IN_W-1:0] = in_imm;
    zx = '0;
    zx[IN_W-1:0] = in_imm;
    up = '0;
    up[OUT_W-1 -: IN_W] = in_imm;
    ext = in_mode == 2'd0 ? sx : in_mode == 2'd1 ? zx : in_mode == 2'd2 ? up : sx << SHIFT_AMT;
  end
  assign it = in_valid && in_ready;
  assign ot = main_v && out_ready;
  assign out_valid = main_v;
  assign out_data = main_d;
  // skid drains first; in_ready only falls once skid actually holds data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
      in_ready <= 1'b1;
    end else if (ot && skid_v) begin
      main_d <= skid_d;
      skid_v <= 1'b0;
      in_ready <= 1'b1;
    end else if (ot || !main_v) begin
      main_v <= it;
      if (it) main_d <= ext;
    end else if (it) begin
      skid_v <= 1'b1;
      skid_d <= ext;
      in_ready <= 1'b0;
    end
  end
endmodule
